// File: rtl/uart_irq_pkg.sv
// Shared IIR codes and rx trigger-level decode for the UART interrupt scheduler.
package uart_irq_pkg;

  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_THRE = 4'b0010;

  // Element count at which rx data available is reported.
  function automatic logic [4:0] trg_cnt(input logic [1:0] trg_level);
    case (trg_level)
      2'b00:   trg_cnt = 5'd1;
      2'b01:   trg_cnt = 5'd4;
      2'b10:   trg_cnt = 5'd8;
      default: trg_cnt = 5'd14;
    endcase
  endfunction

endpackage

// File: rtl/uart_cti_timer.sv
// Character-timeout timer: counts bit ticks while rx data sits idle and flags CTI
// once CTI_CHARS full frames have elapsed without a push or pop.
module uart_cti_timer #(
  parameter int CTI_CHARS = 4,
  parameter int EW        = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [EW-1:0] rx_elem_i,
  input  logic          rx_push_i,
  input  logic          rx_pop_i,
  input  logic          bit_tick_i,
  input  logic [3:0]    frame_bits_i,
  output logic          cti_pend_o,
  output logic          cti_pend_nxt_o
);

  localparam int CW = $clog2(CTI_CHARS * 12 + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] limit;
  logic          pend_q;
  logic          pend_nxt;
  logic          restart;

  assign limit   = CW'(CTI_CHARS) * CW'(frame_bits_i);
  assign restart = rx_push_i | rx_pop_i | (rx_elem_i == '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_nxt  = cnt_q;
    pend_nxt = pend_q;
    if (restart) begin
      cnt_nxt  = '0;
      pend_nxt = 1'b0;
    end else begin
      // Compare with < so a shrinking frame_bits never lets the count wrap.
      if (bit_tick_i && (cnt_q < limit)) cnt_nxt = cnt_q + CW'(1);
      if (cnt_q == limit)                pend_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      pend_q <= pend_nxt;
    end
  end

  assign cti_pend_o     = pend_q;
  assign cti_pend_nxt_o = pend_nxt;

endmodule

// File: rtl/uart_irq_sched.sv
// 16550-style interrupt scheduler: pending flags for RLS/RDA/CTI/THRE, enable masking,
// fixed priority and a registered IIR code with a glitch-free irq_o.
module uart_irq_sched
  import uart_irq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  parameter int CTI_CHARS      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [2:0]                ier_i,
  input  logic [1:0]                trg_level_i,
  input  logic [LOG_FIFO_DEPTH:0]   rx_elem_i,
  input  logic [LOG_FIFO_DEPTH:0]   tx_elem_i,
  input  logic                      rx_push_i,
  input  logic                      rx_pop_i,
  input  logic                      lsr_err_i,
  input  logic                      lsr_rd_i,
  input  logic                      iir_rd_i,
  input  logic                      thr_wr_i,
  input  logic                      bit_tick_i,
  input  logic [3:0]                frame_bits_i,
  output logic [3:0]                iir_o,
  output logic                      irq_o
);

  localparam int EW = LOG_FIFO_DEPTH + 1;

  logic       rls_q, rls_nxt;
  logic       thre_q, thre_nxt, thre_set, thre_clr;
  logic       tx_nz_q;
  logic       thre_en_q;
  logic       rda;
  logic       cti_pend, cti_nxt;
  logic [3:0] iir_q, iir_nxt;

  uart_cti_timer #(
    .CTI_CHARS (CTI_CHARS),
    .EW        (EW)
  ) u_cti_timer (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rx_elem_i      (rx_elem_i),
    .rx_push_i      (rx_push_i),
    .rx_pop_i       (rx_pop_i),
    .bit_tick_i     (bit_tick_i),
    .frame_bits_i   (frame_bits_i),
    .cti_pend_o     (cti_pend),
    .cti_pend_nxt_o (cti_nxt)
  );

  assign rda = rx_elem_i >= EW'(trg_cnt(trg_level_i));

  assign thre_set = (tx_elem_i == '0) && (tx_nz_q || (ier_i[1] && !thre_en_q));
  assign thre_clr = thr_wr_i || (iir_rd_i && (iir_q == IIR_THRE));

  // The IIR is driven from next-state flags so any event shows up exactly one edge later.
  always_comb begin
    rls_nxt = rls_q;
    if (lsr_rd_i)  rls_nxt = 1'b0;
    if (lsr_err_i) rls_nxt = 1'b1;

    thre_nxt = thre_clr ? 1'b0 : (thre_q | thre_set);

    iir_nxt = IIR_NONE;
    if      (ier_i[2] && rls_nxt)  iir_nxt = IIR_RLS;
    else if (ier_i[0] && rda)      iir_nxt = IIR_RDA;
    else if (ier_i[0] && cti_nxt)  iir_nxt = IIR_CTI;
    else if (ier_i[1] && thre_nxt) iir_nxt = IIR_THRE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rls_q     <= 1'b0;
      thre_q    <= 1'b0;
      tx_nz_q   <= 1'b0;
      thre_en_q <= 1'b0;
      iir_q     <= IIR_NONE;
    end else begin
      rls_q     <= rls_nxt;
      thre_q    <= thre_nxt;
      tx_nz_q   <= (tx_elem_i != '0);
      thre_en_q <= ier_i[1];
      iir_q     <= iir_nxt;
    end
  end

  assign iir_o = iir_q;
  assign irq_o = ~iir_q[0];

endmodule

// File: tb/tb_uart_irq_sched.sv
// Directed self-checking bench for uart_irq_sched: reset, priority, CTI timing,
// THRE set/clear, masking and mid-timeout reset.
module tb_uart_irq_sched;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] ier_i;
  logic [1:0] trg_level_i;
  logic [4:0] rx_elem_i;
  logic [4:0] tx_elem_i;
  logic       rx_push_i, rx_pop_i, lsr_err_i, lsr_rd_i, iir_rd_i, thr_wr_i, bit_tick_i;
  logic [3:0] frame_bits_i;
  logic [3:0] iir_o;
  logic       irq_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] NONE = 4'b0001;
  localparam logic [3:0] RLS  = 4'b0110;
  localparam logic [3:0] RDA  = 4'b0100;
  localparam logic [3:0] CTI  = 4'b1100;
  localparam logic [3:0] THRE = 4'b0010;

  uart_irq_sched #(.FIFO_DEPTH(16), .CTI_CHARS(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ier_i        (ier_i),
    .trg_level_i  (trg_level_i),
    .rx_elem_i    (rx_elem_i),
    .tx_elem_i    (tx_elem_i),
    .rx_push_i    (rx_push_i),
    .rx_pop_i     (rx_pop_i),
    .lsr_err_i    (lsr_err_i),
    .lsr_rd_i     (lsr_rd_i),
    .iir_rd_i     (iir_rd_i),
    .thr_wr_i     (thr_wr_i),
    .bit_tick_i   (bit_tick_i),
    .frame_bits_i (frame_bits_i),
    .iir_o        (iir_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bit_tick_i = 1'b1;
      step();
    end
    bit_tick_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic check_iir(input string tag, input logic [3:0] exp);
    check(tag, iir_o, exp);
    check({tag, "_irq"}, {3'b000, irq_o}, {3'b000, ~exp[0]});
  endtask

  initial begin
    rst_i = 1'b1; ier_i = 3'b000; trg_level_i = 2'b00;
    rx_elem_i = 5'd0; tx_elem_i = 5'd5;
    rx_push_i = 1'b0; rx_pop_i = 1'b0; lsr_err_i = 1'b1; lsr_rd_i = 1'b0;
    iir_rd_i = 1'b0; thr_wr_i = 1'b0; bit_tick_i = 1'b0; frame_bits_i = 4'd10;

    // 1. Reset with an error pending on the line.
    step();
    check_iir("rst_c1", NONE);
    step();
    check_iir("rst_c2", NONE);
    rst_i = 1'b0; lsr_err_i = 1'b0;
    step();
    check_iir("rst_release", NONE);

    // 2. Priority and trigger levels.
    ier_i = 3'b111; trg_level_i = 2'b01;
    step();
    check_iir("prio_idle", NONE);
    rx_elem_i = 5'd4;
    step();
    check_iir("prio_rda4", RDA);
    lsr_err_i = 1'b1; step(); lsr_err_i = 1'b0;
    check_iir("prio_rls", RLS);
    lsr_rd_i = 1'b1; step(); lsr_rd_i = 1'b0;
    check_iir("prio_lsr_rd", RDA);
    rx_elem_i = 5'd3; rx_pop_i = 1'b1; step(); rx_pop_i = 1'b0;
    check_iir("prio_drain3", NONE);
    trg_level_i = 2'b00; step();
    check_iir("trg1_elem3", RDA);
    trg_level_i = 2'b11; rx_elem_i = 5'd13; step();
    check_iir("trg14_elem13", NONE);
    rx_elem_i = 5'd14; step();
    check_iir("trg14_elem14", RDA);
    rx_elem_i = 5'd16; step();
    check_iir("trg14_full", RDA);
    rx_elem_i = 5'd0; step();
    check_iir("rx_empty", NONE);

    // 3. Character timeout: 4 chars x 10 bits = 40 ticks.
    ier_i = 3'b000; do_reset();
    ier_i = 3'b001; trg_level_i = 2'b10; rx_elem_i = 5'd2; frame_bits_i = 4'd10;
    step();
    ticks(39);
    check_iir("cti_39", NONE);
    ticks(1);
    check_iir("cti_40_edge", NONE);
    step();
    check_iir("cti_fire", CTI);
    rx_elem_i = 5'd1; rx_pop_i = 1'b1; step(); rx_pop_i = 1'b0;
    check_iir("cti_pop", NONE);
    ticks(39);
    rx_elem_i = 5'd2; rx_push_i = 1'b1; step(); rx_push_i = 1'b0;
    check_iir("cti_push39", NONE);
    ticks(39);
    step();
    check_iir("cti_restart_39", NONE);
    ticks(1);
    step();
    check_iir("cti_restart_fire", CTI);
    rx_elem_i = 5'd8; step();
    check_iir("rda_over_cti", RDA);
    rx_elem_i = 5'd2; step();
    check_iir("cti_held", CTI);
    ier_i = 3'b000; step();
    check_iir("cti_masked", NONE);
    ier_i = 3'b001; step();
    check_iir("cti_unmasked", CTI);
    rx_elem_i = 5'd0; step();
    check_iir("cti_rx_empty", NONE);

    // Shorter frame: 4 x 7 = 28 ticks.
    frame_bits_i = 4'd7; rx_elem_i = 5'd1; step();
    ticks(27); step();
    check_iir("cti7_27", NONE);
    ticks(1); step();
    check_iir("cti7_fire", CTI);

    // 4. THRE set and clear paths.
    ier_i = 3'b000; rx_elem_i = 5'd0; tx_elem_i = 5'd1; frame_bits_i = 4'd10;
    do_reset();
    ier_i = 3'b010; step();
    check_iir("thre_en_tx_busy", NONE);
    tx_elem_i = 5'd0; step();
    check_iir("thre_tx_drain", THRE);
    iir_rd_i = 1'b1; step(); iir_rd_i = 1'b0;
    check_iir("thre_iir_rd", NONE);
    step();
    check_iir("thre_steady_empty", NONE);
    ier_i = 3'b000; step();
    ier_i = 3'b010; step();
    check_iir("thre_enable_rise", THRE);
    thr_wr_i = 1'b1; step(); thr_wr_i = 1'b0;
    check_iir("thre_thr_wr", NONE);
    tx_elem_i = 5'd3; step();
    tx_elem_i = 5'd0; thr_wr_i = 1'b1; step(); thr_wr_i = 1'b0;
    check_iir("thre_clr_wins", NONE);
    step();
    check_iir("thre_clr_wins_after", NONE);

    // 5. Masking keeps RLS pending; set beats clear.
    ier_i = 3'b000; tx_elem_i = 5'd5; do_reset();
    lsr_err_i = 1'b1; step(); lsr_err_i = 1'b0;
    check_iir("rls_masked", NONE);
    step();
    ier_i = 3'b100; step();
    check_iir("rls_unmasked", RLS);
    lsr_err_i = 1'b1; lsr_rd_i = 1'b1; step(); lsr_err_i = 1'b0; lsr_rd_i = 1'b0;
    check_iir("rls_set_wins", RLS);
    lsr_rd_i = 1'b1; step(); lsr_rd_i = 1'b0;
    check_iir("rls_cleared", NONE);

    // 6. Reset in the middle of a timeout restarts the full 40 ticks.
    ier_i = 3'b000; do_reset();
    ier_i = 3'b001; trg_level_i = 2'b10; rx_elem_i = 5'd2; frame_bits_i = 4'd10;
    step();
    ticks(30);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    check_iir("midrst", NONE);
    ticks(39); step();
    check_iir("midrst_39", NONE);
    ticks(1); step();
    check_iir("midrst_fire", CTI);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
